// File: rtl/pmem_responder.sv
// pmem_responder: block-organised backing store for the cache pmem port.
// Accepts one 128-bit read or writeback at a time.
// Each transaction completes after a fixed LATENCY with a one-cycle pmem_resp.
module pmem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  // RAM contents are undefined at power-up unless the memory flow preloads INIT_FILE.
  localparam bit unused_init_file = (INIT_FILE != "");

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [127:0]            wdata_q, wdata_d;
  logic [127:0]            rdata_q, rdata_d;
  logic [15:0]             rd_cnt_q, rd_cnt_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;

  logic [127:0]            mem [DEPTH];
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_idx;
  logic [127:0]            mem_wdata;

  logic [DEPTH_LOG2-1:0]   addr_idx;
  logic                    req_new;
  logic                    req_held;
  logic                    last_cycle;
  logic                    unused_addr_bits;

  assign addr_idx         = pmem_address[DEPTH_LOG2+3:4];
  assign unused_addr_bits = ^pmem_address;
  assign req_new          = pmem_write | pmem_read;
  assign req_held         = op_wr_q ? pmem_write : pmem_read;
  // Counter starts at LATENCY-1; the edge that takes it to zero is the one entering RESP,
  // so the decision is made while it still reads 1.
  assign last_cycle       = (cnt_q == 8'd1);

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_new) state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
      end
      S_BUSY: begin
        if (!req_held)      state_d = S_IDLE;
        else if (last_cycle) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latching, latency counting, RAM access and completion counters.
  always_comb begin
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    mem_we    = 1'b0;
    mem_idx   = idx_q;
    mem_wdata = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_new) begin
          op_wr_d = pmem_write;
          idx_d   = addr_idx;
          cnt_d   = LAT_M1;
          if (pmem_write) wdata_d = pmem_wdata;
          // Single-cycle latency skips BUSY, so the access happens straight from the inputs.
          if (LATENCY == 1) begin
            mem_idx = addr_idx;
            if (pmem_write) begin
              mem_we    = 1'b1;
              mem_wdata = pmem_wdata;
            end else begin
              rdata_d = mem[addr_idx];
            end
          end
        end
      end
      S_BUSY: begin
        if (!req_held) begin
          cnt_d = '0;
        end else if (last_cycle) begin
          cnt_d = '0;
          if (op_wr_q) mem_we  = 1'b1;
          else         rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (op_wr_q) begin
          if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
          if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // Block RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wdata;
  end

  assign pmem_resp  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign pmem_rdata = rdata_q;
  assign rd_count   = rd_cnt_q;
  assign wr_count   = wr_cnt_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a LATENCY=4 instance driven from a cycle table,
// plus hand sequences for abort, mid-transaction reset and a LATENCY=1 aliasing instance.
module tb_pmem_responder;

  localparam logic [127:0] DATA_D = 128'hDEAD_0011_2233_4455_6677_8899_AABB_BEEF;

  logic clk;
  logic reset_n;

  logic         rd_a, wr_a, resp_a, busy_a;
  logic [15:0]  addr_a, rdc_a, wrc_a;
  logic [127:0] wd_a, rdata_a;

  logic         rd_b, wr_b, resp_b, busy_b;
  logic [15:0]  addr_b, rdc_b, wrc_b;
  logic [127:0] wd_b, rdata_b;

  logic         use_b;
  logic         resp_s;
  logic [127:0] rdata_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wd;
    logic         resp;
    logic         busy;
    logic [127:0] rdata;
    logic [15:0]  rdc;
    logic [15:0]  wrc;
  } vec_t;

  vec_t vecs[23];

  pmem_responder #(.LATENCY(4), .DEPTH_LOG2(8), .INIT_FILE("")) dut_a (
    .clk(clk), .reset_n(reset_n),
    .pmem_read(rd_a), .pmem_write(wr_a), .pmem_address(addr_a), .pmem_wdata(wd_a),
    .pmem_resp(resp_a), .pmem_rdata(rdata_a), .busy(busy_a),
    .rd_count(rdc_a), .wr_count(wrc_a)
  );

  pmem_responder #(.LATENCY(1), .DEPTH_LOG2(2), .INIT_FILE("")) dut_b (
    .clk(clk), .reset_n(reset_n),
    .pmem_read(rd_b), .pmem_write(wr_b), .pmem_address(addr_b), .pmem_wdata(wd_b),
    .pmem_resp(resp_b), .pmem_rdata(rdata_b), .busy(busy_b),
    .rd_count(rdc_b), .wr_count(wrc_b)
  );

  assign resp_s  = use_b ? resp_b  : resp_a;
  assign rdata_s = use_b ? rdata_b : rdata_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [127:0] wd, input logic resp, input logic busy,
                             input logic [127:0] rdata, input logic [15:0] rdc,
                             input logic [15:0] wrc);
    vec_t t;
    t.rd = rd; t.wr = wr; t.addr = addr; t.wd = wd; t.resp = resp; t.busy = busy;
    t.rdata = rdata; t.rdc = rdc; t.wrc = wrc;
    return t;
  endfunction

  task automatic drive(input bit b, input logic rd, input logic wr,
                       input logic [15:0] addr, input logic [127:0] wd);
    if (b) begin
      rd_b = rd; wr_b = wr; addr_b = addr; wd_b = wd;
    end else begin
      rd_a = rd; wr_a = wr; addr_a = addr; wd_a = wd;
    end
  endtask

  // Starts at posedge+1; holds the request until pmem_resp, then drops it and idles one cycle.
  task automatic txn(input bit b, input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [127:0] wd, input int lat, input string nm);
    int found;
    found = -1;
    use_b = b;
    drive(b, rd, wr, addr, wd);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_s === 1'b1) begin
        found = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    drive(b, 1'b0, 1'b0, 16'h0, '0);
    chk({nm, "_latency"}, 128'(found), 128'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    use_b = 1'b0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, '0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, '0);

    // cycle table: write 0x120, read it back, then simultaneous rd+wr at 0x40 and read back
    vecs[0]  = v(0, 1, 16'h0120, DATA_D, 0, 0, '0, 0, 0);
    vecs[1]  = v(0, 1, 16'h0120, DATA_D, 0, 1, '0, 0, 0);
    vecs[2]  = v(0, 1, 16'h0120, DATA_D, 0, 1, '0, 0, 0);
    vecs[3]  = v(0, 1, 16'h0120, DATA_D, 0, 1, '0, 0, 0);
    vecs[4]  = v(0, 1, 16'h0120, DATA_D, 1, 1, '0, 0, 0);
    vecs[5]  = v(1, 0, 16'h0120, '0, 0, 0, '0, 0, 1);
    vecs[6]  = v(1, 0, 16'h0120, '0, 0, 1, '0, 0, 1);
    vecs[7]  = v(1, 0, 16'h0120, '0, 0, 1, '0, 0, 1);
    vecs[8]  = v(1, 0, 16'h0120, '0, 0, 1, '0, 0, 1);
    vecs[9]  = v(1, 0, 16'h0120, '0, 1, 1, DATA_D, 0, 1);
    vecs[10] = v(0, 0, 16'h0000, '0, 0, 0, DATA_D, 1, 1);
    vecs[11] = v(1, 1, 16'h0040, 128'h1, 0, 0, DATA_D, 1, 1);
    vecs[12] = v(1, 1, 16'h0040, 128'h1, 0, 1, DATA_D, 1, 1);
    vecs[13] = v(1, 1, 16'h0040, 128'h1, 0, 1, DATA_D, 1, 1);
    vecs[14] = v(1, 1, 16'h0040, 128'h1, 0, 1, DATA_D, 1, 1);
    vecs[15] = v(1, 1, 16'h0040, 128'h1, 1, 1, DATA_D, 1, 1);
    vecs[16] = v(0, 0, 16'h0000, '0, 0, 0, DATA_D, 1, 2);
    vecs[17] = v(1, 0, 16'h0040, '0, 0, 0, DATA_D, 1, 2);
    vecs[18] = v(1, 0, 16'h0040, '0, 0, 1, DATA_D, 1, 2);
    vecs[19] = v(1, 0, 16'h0040, '0, 0, 1, DATA_D, 1, 2);
    vecs[20] = v(1, 0, 16'h0040, '0, 0, 1, DATA_D, 1, 2);
    vecs[21] = v(1, 0, 16'h0040, '0, 1, 1, 128'h1, 1, 2);
    vecs[22] = v(0, 0, 16'h0000, '0, 0, 0, 128'h1, 2, 2);

    #12;
    chk("reset_resp",  128'(resp_a),  128'(0));
    chk("reset_busy",  128'(busy_a),  128'(0));
    chk("reset_rdata", rdata_a,       '0);
    chk("reset_rdc",   128'(rdc_a),   128'(0));
    chk("reset_wrc",   128'(wrc_a),   128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      drive(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d_resp", i),  128'(resp_a), 128'(vecs[i].resp));
      chk($sformatf("vec%0d_busy", i),  128'(busy_a), 128'(vecs[i].busy));
      chk($sformatf("vec%0d_rdata", i), rdata_a,      vecs[i].rdata);
      chk($sformatf("vec%0d_rdc", i),   128'(rdc_a),  128'(vecs[i].rdc));
      chk($sformatf("vec%0d_wrc", i),   128'(wrc_a),  128'(vecs[i].wrc));
      @(posedge clk); #1;
    end

    // aborted write must leave the line and counters untouched
    txn(1'b0, 1'b0, 1'b1, 16'h0200, 128'h77, 4, "wr200");
    chk("wr200_wrc", 128'(wrc_a), 128'(3));
    drive(1'b0, 1'b0, 1'b1, 16'h0200, 128'h5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, '0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_a) seen++;
    end
    @(posedge clk); #1;
    chk("abort_noresp", 128'(seen), 128'(0));
    chk("abort_wrc", 128'(wrc_a), 128'(3));
    txn(1'b0, 1'b1, 1'b0, 16'h0200, '0, 4, "rd200");
    chk("abort_rdata", rdata_a, 128'h77);
    chk("abort_rdc", 128'(rdc_a), 128'(3));

    // reset in cycle 2 of a write cancels it
    drive(1'b0, 1'b0, 1'b1, 16'h0200, 128'h99);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_resp",  128'(resp_a), 128'(0));
    chk("rst_mid_busy",  128'(busy_a), 128'(0));
    chk("rst_mid_rdata", rdata_a,      '0);
    chk("rst_mid_rdc",   128'(rdc_a),  128'(0));
    chk("rst_mid_wrc",   128'(wrc_a),  128'(0));
    drive(1'b0, 1'b0, 1'b0, 16'h0, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_a) seen++;
    end
    @(posedge clk); #1;
    chk("rst_noresp", 128'(seen), 128'(0));
    txn(1'b0, 1'b1, 1'b0, 16'h0200, '0, 4, "rst_rd200");
    chk("rst_line_kept", rdata_a, 128'h77);
    chk("rst_rdc", 128'(rdc_a), 128'(1));
    chk("rst_wrc", 128'(wrc_a), 128'(0));

    // LATENCY=1, 4-line RAM: 0x0040 and 0x0000 map to the same line
    txn(1'b1, 1'b0, 1'b1, 16'h0040, DATA_D, 1, "b_wr40");
    chk("b_wrc", 128'(wrc_b), 128'(1));
    txn(1'b1, 1'b1, 1'b0, 16'h0000, '0, 1, "b_rd00");
    chk("b_alias_rdata", rdata_b, DATA_D);
    chk("b_rdc", 128'(rdc_b), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Physical-memory responder that sits on the far side of the cache's pmem interface, answering 128-bit block reads and writebacks issued by the cache controller. Holds a block-organised RAM, applies a programmable fixed access latency, and returns a single-cycle `pmem_resp` pulse per transaction. Used as the synthesizable backing store for the LC-3b memory hierarchy, and as the cache's counterpart in system-level benches.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `pmem_resp`; legal range 1–255.
- `DEPTH_LOG2`, 8: log2 of the number of 16-byte lines; legal range 1–12.
- `INIT_FILE`, "": hex image loaded into the RAM at elaboration; empty means contents are undefined.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `pmem_read`  in  1  block read request; held until `pmem_resp`.
- `pmem_write`  in  1  block write request; held until `pmem_resp`.
- `pmem_address`  in  16 (`lc3b_word`)  byte address; bits [3:0] are ignored.
- `pmem_wdata`  in  128 (`lc3b_block`)  writeback data; held with `pmem_write`.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_rdata`  out  128 (`lc3b_block`)  read data; valid in the `pmem_resp` cycle.
- `busy`  out  1  high while in BUSY or RESP.
- `rd_count`  out  16  completed reads; saturates at 16'hFFFF.
- `wr_count`  out  16  completed writes; saturates at 16'hFFFF.

## Operation
- Line index is `pmem_address[DEPTH_LOG2+3:4]`. Address bits above the index are ignored, so addresses alias modulo 2^(DEPTH_LOG2+4) bytes.
- The FSM has three states: IDLE, BUSY and RESP.
- IDLE:
  - If `pmem_write` is high: latch index, latch `pmem_wdata`, set op=write, load counter with LATENCY-1, and go to BUSY.
  - Else if `pmem_read` is high: latch index, set op=read, load counter, and go to BUSY.
  - If both are high, the write wins. The read is not serviced in this transaction.
  - If LATENCY=1, go directly to RESP. The BUSY side-effects below still apply on that same edge.
- BUSY:
  - If the request for the latched op has dropped (`pmem_write` for a write, `pmem_read` for a read), abort. Return to IDLE with no RAM write, no `pmem_resp`, and no count change.
  - Else, when the counter is 0, go to RESP. On that edge, a write commits `wdata` to `ram[index]`; a read loads `pmem_rdata <= ram[index]`.
  - Else decrement the counter.
- RESP:
  - `pmem_resp` is high for exactly this cycle.
  - Increment the matching counter, saturating.
  - Unconditionally return to IDLE.
- A read of a line written by an earlier completed transaction returns the new data.
- `pmem_rdata` holds its last loaded value outside RESP. Write transactions do not change it.
- Address and data changes during BUSY are ignored because the latched copies are used.

## Timing
- Reset, asynchronous, applies at once: state=IDLE, counter=0, `pmem_resp`=0, `pmem_rdata`=0, `busy`=0, `rd_count`=0, `wr_count`=0. RAM contents are not affected.
- Reset asserted mid-transaction cancels it. A pending write is not committed.
- Latency: request first seen high in IDLE at cycle 0, then `pmem_resp` high in cycle LATENCY, then IDLE in cycle LATENCY+1.
- There is at least one IDLE cycle between transactions, so back-to-back requests complete every LATENCY+1 cycles.
- The requester must deassert or change its request in the cycle after `pmem_resp`. A request still high in that IDLE cycle is treated as a new transaction.
- `busy` is registered: high from cycle 1 through cycle LATENCY.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then hold `pmem_write`=1, address 16'h0120, wdata=128'hDEAD…BEEF with LATENCY=4, for 4 cycles. Required: `pmem_resp` high in cycle 4 only, and `wr_count`=1.
- Then read 16'h0120 (drop write, raise read the cycle after resp). Required: `pmem_resp` 4 cycles later with `pmem_rdata`=128'hDEAD…BEEF, and `rd_count`=1.
- Assert read and write together at 16'h0040 with wdata=128'h1. Required: a write is performed, `wr_count` increments and `rd_count` does not, and a subsequent read of 16'h0040 returns 128'h1.
- Raise a write to 16'h0200 with wdata=128'h5, drop it in cycle 2, then read 16'h0200. Required: no `pmem_resp` for the aborted write, and the read returns the prior contents, not 128'h5.
- Drive `reset_n` low in cycle 2 of a write. Required: outputs clear immediately, no `pmem_resp` occurs, and the line is unchanged.
- Run the first scenario with LATENCY=1 and DEPTH_LOG2=2 at address 16'h0040. Required: `pmem_resp` in cycle 1, and a read of 16'h0000 returns the same data (aliasing).
